fetch_unit: RTL



---
 rtl/fetch_unit.sv | 87 ++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage and IF/ID pipeline register for the five-stage MIPS core.
// Define DELAY_SLOT_EN so the instruction after a taken redirect executes as a delay slot.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pcplus4,
  output logic        id_valid,
  output logic        fetch_err
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;
  assign im_addr  = pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      id_instr   <= NOP_WORD;
      id_pc      <= 32'h0;
      id_pcplus4 <= 32'h0;
      id_valid   <= 1'b0;
      fetch_err  <= 1'b0;
    end else begin
      case (state_q)
        StBoot: state_q <= StRun;
        StRun: begin
          // Stall freezes everything; a redirect seen under stall is re-issued by ID later.
          if (stall) begin
            state_q <= StRun;
          end else if (redirect_valid) begin
            if (redirect_pc[1:0] != 2'b00) begin
              state_q   <= StHalt;
              fetch_err <= 1'b1;
              id_instr  <= NOP_WORD;
              id_valid  <= 1'b0;
            end else begin
              pc_q <= redirect_pc;
`ifdef DELAY_SLOT_EN
              id_instr   <= im_rdata;
              id_pc      <= pc_q;
              id_pcplus4 <= pc_plus4;
              id_valid   <= 1'b1;
`else
              id_instr   <= NOP_WORD;
              id_pc      <= 32'h0;
              id_pcplus4 <= 32'h0;
              id_valid   <= 1'b0;
`endif
            end
          end else begin
            pc_q       <= pc_plus4;
            id_instr   <= im_rdata;
            id_pc      <= pc_q;
            id_pcplus4 <= pc_plus4;
            id_valid   <= 1'b1;
          end
        end
        StHalt: begin
          id_instr <= NOP_WORD;
          id_valid <= 1'b0;
        end
        default: begin
          state_q  <= StHalt;
          id_instr <= NOP_WORD;
          id_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
